// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl
//   Conditional-execution sequencer. Owns the architectural NZCV flags
//   register, accepts one instruction at a time, evaluates its condition
//   field against the registered flags, then either drives the execute
//   datapath (waiting on the ALU with a watchdog) or annuls the instruction.
//
// Ports
//   Clk        in   clock, rising edge
//   Reset_n    in   synchronous reset, active-low
//   IR         in   instruction, IR[31:28] condition field
//   IR_valid   in   instruction presented
//   IR_ready   out  block can accept an instruction (IDLE)
//   Alu_flags  in   ALU result flags {C,N,V,Z}
//   Alu_done   in   ALU operation complete (sampled in EXEC only)
//   Flag_wr    in   external flags write
//   Flag_wdata in   external flags write data {C,N,V,Z}
//   Flags      out  flags register {C,N,V,Z}
//   Exec_en    out  high in every EXEC cycle
//   Retire     out  1-cycle pulse, instruction executed
//   Skip       out  1-cycle pulse, condition failed
//   Undef      out  1-cycle pulse, condition 4'b1111
//   Err        out  1-cycle pulse, ALU watchdog expired
module cond_exec_ctrl #(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned SBIT_POS = 20
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] IR,
  input  logic        IR_valid,
  output logic        IR_ready,
  input  logic [3:0]  Alu_flags,
  input  logic        Alu_done,
  input  logic        Flag_wr,
  input  logic [3:0]  Flag_wdata,
  output logic [3:0]  Flags,
  output logic        Exec_en,
  output logic        Retire,
  output logic        Skip,
  output logic        Undef,
  output logic        Err
);

  localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EVAL, EXEC, DONE} state_t;
  typedef enum logic [1:0] {RES_RETIRE, RES_SKIP, RES_UNDEF, RES_ERR} result_t;

  state_t        state, state_nx;
  result_t       result, result_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    cond_q;
  logic          sbit_q;
  logic [3:0]    flags_q;
  logic          ld_ir;
  logic          alu_wb;
  logic          pass;
  logic          fc, fn, fv, fz;

  // Only the condition field and the S bit of the instruction are needed.
  logic unused_ir;
  assign unused_ir = ^IR;

  assign {fc, fn, fv, fz} = flags_q;

  always_comb begin
    pass = 1'b0;
    case (cond_q)
      4'h0: pass = fz;
      4'h1: pass = !fz;
      4'h2: pass = fc;
      4'h3: pass = !fc;
      4'h4: pass = fn;
      4'h5: pass = !fn;
      4'h6: pass = fv;
      4'h7: pass = !fv;
      4'h8: pass = fc && !fz;
      4'h9: pass = !fc || fz;
      4'hA: pass = (fn == fv);
      4'hB: pass = (fn != fv);
      4'hC: pass = !fz && (fn == fv);
      4'hD: pass = fz || (fn != fv);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    result_nx = result;
    cnt_nx    = cnt;
    case (state)
      IDLE: if (IR_valid) state_nx = EVAL;
      EVAL: begin
        if (cond_q == 4'hF) begin
          result_nx = RES_UNDEF;
          state_nx  = DONE;
        end else if (pass) begin
          cnt_nx   = '0;
          state_nx = EXEC;
        end else begin
          result_nx = RES_SKIP;
          state_nx  = DONE;
        end
      end
      EXEC: begin
        if (Alu_done) begin
          result_nx = RES_RETIRE;
          state_nx  = DONE;
        end else if (cnt == CNT_LAST) begin
          result_nx = RES_ERR;
          state_nx  = DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ld_ir  = (state == IDLE) && IR_valid;
  assign alu_wb = (state == EXEC) && Alu_done && sbit_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      result  <= RES_RETIRE;
      cnt     <= '0;
      cond_q  <= '0;
      sbit_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state  <= state_nx;
      result <= result_nx;
      cnt    <= cnt_nx;
      if (ld_ir) begin
        cond_q <= IR[31:28];
        sbit_q <= IR[SBIT_POS];
      end
      // ALU writeback takes priority over a simultaneous external write.
      if (alu_wb)
        flags_q <= Alu_flags;
      else if (Flag_wr)
        flags_q <= Flag_wdata;
    end
  end

  assign Flags    = flags_q;
  assign IR_ready = (state == IDLE);
  assign Exec_en  = (state == EXEC);
  assign Retire   = (state == DONE) && (result == RES_RETIRE);
  assign Skip     = (state == DONE) && (result == RES_SKIP);
  assign Undef    = (state == DONE) && (result == RES_UNDEF);
  assign Err      = (state == DONE) && (result == RES_ERR);

endmodule

// File: tb/tb_cond_exec_ctrl.sv
module tb_cond_exec_ctrl;

  localparam int TO = 16;

  localparam int K_RETIRE = 0;
  localparam int K_SKIP   = 1;
  localparam int K_UNDEF  = 2;
  localparam int K_ERR    = 3;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] IR;
  logic        IR_valid;
  logic        IR_ready;
  logic [3:0]  Alu_flags;
  logic        Alu_done;
  logic        Flag_wr;
  logic [3:0]  Flag_wdata;
  logic [3:0]  Flags;
  logic        Exec_en;
  logic        Retire;
  logic        Skip;
  logic        Undef;
  logic        Err;

  cond_exec_ctrl #(.TIMEOUT(TO), .SBIT_POS(20)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .IR(IR), .IR_valid(IR_valid),
    .IR_ready(IR_ready), .Alu_flags(Alu_flags), .Alu_done(Alu_done),
    .Flag_wr(Flag_wr), .Flag_wdata(Flag_wdata), .Flags(Flags),
    .Exec_en(Exec_en), .Retire(Retire), .Skip(Skip), .Undef(Undef), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         kind;
    int         lat;
    int         execs;
    logic [3:0] flags;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] model_flags = 4'b0000;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference condition evaluation, flags packed {C,N,V,Z}.
  function automatic bit cond_ok(input logic [3:0] code, input logic [3:0] f);
    bit c, n, v, z;
    c = f[3]; n = f[2]; v = f[1]; z = f[0];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Output monitor: latency counted from the accept edge (cycle 0).
  int lat   = 0;
  int execs = 0;
  always @(negedge Clk) begin
    int   npulse;
    int   kind;
    exp_t e;
    if (!Reset_n) begin
      lat   = 0;
      execs = 0;
    end else begin
      if (IR_valid && IR_ready) begin
        lat   = 0;
        execs = 0;
      end else begin
        lat++;
      end
      if (Exec_en) execs++;
      npulse = int'(Retire) + int'(Skip) + int'(Undef) + int'(Err);
      if (npulse != 0) begin
        check("pulse_onehot", npulse, 1);
        kind = Retire ? K_RETIRE : Skip ? K_SKIP : Undef ? K_UNDEF : K_ERR;
        check("sb_pending", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("result_kind", kind, e.kind);
          check("latency", lat, e.lat);
          check("exec_cycles", execs, e.execs);
          check("flags_done", int'(Flags), int'(e.flags));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!IR_ready && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!IR_ready) check("ir_ready_wait", int'(IR_ready), 1);
  endtask

  task automatic set_flags(input logic [3:0] val);
    Flag_wr = 1'b1; Flag_wdata = val;
    @(posedge Clk); #1;
    Flag_wr = 1'b0;
    model_flags = val;
    check("flag_wr", int'(Flags), int'(val));
  endtask

  // k: EXEC cycle carrying Alu_done (0 = never).
  // fw_mode: 0 none, 1 Flag_wr with Alu_done, 2 Flag_wr during EVAL.
  task automatic issue(input logic [31:0] ir, input int k, input logic [3:0] af,
                       input int fw_mode, input logic [3:0] fwd);
    exp_t e;
    bit   undef, ok, sbit;
    undef = (ir[31:28] == 4'hF);
    ok    = !undef && cond_ok(ir[31:28], model_flags);
    sbit  = ir[20];
    e.flags = model_flags;
    if (fw_mode == 2) e.flags = fwd;
    if (undef) begin
      e.kind = K_UNDEF; e.lat = 2; e.execs = 0;
    end else if (!ok) begin
      e.kind = K_SKIP; e.lat = 2; e.execs = 0;
    end else if (k == 0) begin
      e.kind = K_ERR; e.lat = 2 + TO; e.execs = TO;
    end else begin
      e.kind = K_RETIRE; e.lat = 2 + k; e.execs = k;
      if (sbit) e.flags = af;
      else if (fw_mode == 1) e.flags = fwd;
    end
    model_flags = e.flags;
    sb.push_back(e);

    wait_ready();
    IR = ir; IR_valid = 1'b1;
    @(posedge Clk); #1;
    IR_valid = 1'b0;
    if (fw_mode == 2) begin Flag_wr = 1'b1; Flag_wdata = fwd; end
    if (ok && k > 0) begin
      repeat (k) begin @(posedge Clk); #1; Flag_wr = 1'b0; end
      Alu_done = 1'b1; Alu_flags = af;
      if (fw_mode == 1) begin Flag_wr = 1'b1; Flag_wdata = fwd; end
    end
    @(posedge Clk); #1;
    Alu_done = 1'b0; Flag_wr = 1'b0;
    wait_ready();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n = 1'b0; IR = '0; IR_valid = 1'b0; Alu_flags = '0;
    Alu_done = 1'b0; Flag_wr = 1'b0; Flag_wdata = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_ir_ready", int'(IR_ready), 1);
    check("rst_exec_en", int'(Exec_en), 0);
    check("rst_flags", int'(Flags), 0);
    check("rst_pulses", int'({Retire, Skip, Undef, Err}), 0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    check("post_rst_ready", int'(IR_ready), 1);

    // EQ with Z=0 is annulled
    issue(32'h0000_0000, 1, 4'b0000, 0, 4'b0000);

    // EQ with S bit, ALU done in 2nd EXEC cycle
    set_flags(4'b0001);
    issue(32'h0010_0000, 2, 4'b1010, 0, 4'b0000);
    @(posedge Clk); #1;
    check("flags_after_s", int'(Flags), 4'b1010);
    set_flags(4'b0001);
    issue(32'h0000_0000, 2, 4'b1010, 0, 4'b0000);

    // LS / HI with C=1, Z=1
    set_flags(4'b1001);
    issue(32'h9000_0000, 1, 4'b0000, 0, 4'b0000);
    issue(32'h8000_0000, 1, 4'b0000, 0, 4'b0000);

    // Full condition sweep
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 15; c++)
        issue({4'(c), 28'h0}, 1 + (c % 3), 4'b0000, 0, 4'b0000);
    end

    // Undef leaves flags alone
    set_flags(4'b0110);
    issue(32'hF010_0000, 1, 4'b1111, 0, 4'b0000);

    // Watchdog expiry and last-cycle retire
    issue(32'hE010_0000, 0, 4'b1111, 0, 4'b0000);
    issue(32'hE010_0000, TO, 4'b1100, 0, 4'b0000);

    // ALU writeback beats a same-edge external write
    issue(32'hE010_0000, 1, 4'b0010, 1, 4'b0100);
    // External write without S bit on the same edge lands
    issue(32'hE000_0000, 3, 4'b1111, 1, 4'b1000);

    // Flag write during EVAL does not affect that evaluation
    set_flags(4'b0000);
    issue(32'h0000_0000, 1, 4'b0000, 2, 4'b0001);

    // Reset in the 3rd EXEC cycle abandons the instruction
    set_flags(4'b0101);
    wait_ready();
    IR = 32'hE010_0000; IR_valid = 1'b1;
    @(posedge Clk); #1;
    IR_valid = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    check("exec_before_rst", int'(Exec_en), 1);
    Reset_n = 1'b0; Flag_wr = 1'b1; Flag_wdata = 4'b1111;
    @(posedge Clk); #1;
    Reset_n = 1'b1; Flag_wr = 1'b0;
    model_flags = 4'b0000;
    check("midrst_exec_en", int'(Exec_en), 0);
    check("midrst_flags", int'(Flags), 0);
    check("midrst_ready", int'(IR_ready), 1);
    repeat (TO + 4) @(posedge Clk);
    #1;

    // Instruction flow still works after the abandoned one
    issue(32'h1000_0000, 1, 4'b0000, 0, 4'b0000);
    repeat (3) @(posedge Clk);
    #1;
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cond_exec_ctrl.md
# cond_exec_ctrl

- Sequences conditional execution for the core: holds the architectural NZCV flags register and accepts one instruction at a time over a valid/ready handshake.
- Evaluates the instruction's condition field against the registered flags, then either enables the execute datapath or annuls the instruction.
- Waits for the ALU to finish, with a watchdog, and writes back flags when the S bit is set.
- Sits between instruction fetch/decode and the ALU. It owns the only flags register in the design.

## Interface

Parameters:
- TIMEOUT, 16: maximum EXEC cycles waited for Alu_done before aborting; must be ≥1.
- SBIT_POS, 20: IR bit index of the S (set-flags) bit.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Reset_n  in  1  synchronous reset, active-low.
- IR  in  32  instruction; IR[31:28] is the condition field.
- IR_valid  in  1  IR presented.
- IR_ready  out  1  block can accept IR.
- Alu_flags  in  4  ALU result flags, packed {C,N,V,Z}.
- Alu_done  in  1  ALU operation complete; sampled only in EXEC.
- Flag_wr  in  1  external (MSR-style) flags write.
- Flag_wdata  in  4  write data {C,N,V,Z}.
- Flags  out  4  current flags register {C,N,V,Z}.
- Exec_en  out  1  high every EXEC cycle.
- Retire  out  1  1-cycle pulse: instruction executed.
- Skip  out  1  1-cycle pulse: condition failed, instruction annulled.
- Undef  out  1  1-cycle pulse: condition 1111.
- Err  out  1  1-cycle pulse: ALU timeout.

## Operation

- **States:** IDLE, EVAL, EXEC, DONE. Every state is 1 cycle except EXEC.
- **IDLE:** IR_ready=1, and IR_ready is 0 in all other states. IR_valid&&IR_ready latches IR into ir_q and moves to EVAL.
- **EVAL:** computes pass from ir_q[31:28] and the Flags register value at that edge.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&&!Z; LS !C||Z.
  - GE N==V; LT N!=V; GT !Z&&N==V; LE Z||N!=V.
  - AL 1.
  - 1111: result=UNDEF, go to DONE.
  - Otherwise fail: result=SKIP, go to DONE. Pass: go to EXEC, clear the watchdog counter.
- **EXEC:**
  - Exec_en=1.
  - Alu_done=1: result=RETIRE, go to DONE. If ir_q[SBIT_POS]=1, Flags<=Alu_flags at the same edge.
  - Alu_done=0 with counter==TIMEOUT-1: result=ERR, go to DONE, flags unchanged.
  - Otherwise the counter increments.
  - Counter width is $clog2(TIMEOUT)+1 and never wraps.
- **DONE:** asserts exactly one of Retire/Skip/Undef/Err according to result, then returns to IDLE.
- **Flag_wr:** honoured in every state, Flags<=Flag_wdata.
  - Collision with an S-bit writeback on the same edge: the ALU value wins.
  - Flag_wr during EVAL does not affect that cycle's evaluation; the old value is used.
- **Result field:** 2-bit register, internal only.

## Timing

- **Reset** (Reset_n=0 at an edge) forces, at that edge:
  - state=IDLE, Flags=4'b0000, counter=0.
  - Exec_en=Retire=Skip=Undef=Err=0.
  - IR_ready=1 from the first cycle after the reset edge.
- **Reset mid-operation:** the instruction is abandoned with no DONE pulse and Exec_en drops the next cycle. A Flag_wr in the reset cycle is ignored.
- **Outputs:** all are Moore, decoded from registered state/result; there are no combinational paths from inputs to outputs.
- **Latency** (accept at edge 0):
  - EVAL in cycle 1.
  - Skip/Undef: DONE in cycle 2, IDLE in cycle 3.
  - Pass: EXEC from cycle 2. With Alu_done in EXEC cycle k (k=1..TIMEOUT), Exec_en is high for k cycles and Retire is in cycle 2+k.
  - Timeout: Exec_en is high for exactly TIMEOUT cycles, then Err.
- **Alu_done on the final allowed cycle** (counter==TIMEOUT-1) retires; it does not raise Err.
- **Throughput:** back-to-back IR_valid is accepted once per visit to IDLE. Minimum spacing is 3 cycles for skipped instructions and 4 for executed ones.
- **Flags timing:** a flags update is visible on Flags and to the next EVAL from the cycle after the updating edge.

## Test plan

- **Reset, then skip:** release reset and present IR=0x00000000 (EQ, Z=0).
  - Required: Skip in cycle 2, Exec_en never high, Flags=0000.
- **Execute with S bit:**
  - Stimulus: Flag_wr with 4'b0001, then IR=0x00100000 (EQ, S=1). Alu_done in 2nd EXEC cycle with Alu_flags=4'b1010.
  - Required: Exec_en high for 2 cycles, Retire in cycle 4, Flags=1010 in the cycle after.
  - Repeat with IR=0x00000000 (S=0): Flags stays 0001.
- **LS/HI with Flags=1001 (C=1, Z=1):**
  - IR=0x90000000 (LS) gives Retire.
  - IR=0x80000000 (HI) gives Skip.
  - Sweep all 15 codes over all 16 flag values against the condition list in Operation.
- **Undef:** IR=0xF0000000 gives Undef in cycle 2, no Exec_en, flags unchanged.
- **Timeout, TIMEOUT=16, IR=0xE0100000, Alu_done never:**
  - Required: Exec_en high for 16 cycles, Err in cycle 18, flags unchanged.
  - Alu_done on the 16th EXEC cycle gives Retire, not Err.
- **Collisions:**
  - Flag_wr=0100 on the same edge as an S-bit Alu_done with Alu_flags=0010: Flags=0010.
  - Reset_n=0 in the 3rd EXEC cycle: no pulse, Exec_en low next cycle, Flags=0000, IR_ready=1.
